// File: rtl/cla_pkg.sv
// Shared definitions for look_ahead16bit-based blocks.
//   CHUNK_W : datapath width of one look_ahead16bit pass
//   st_t    : sequencer state encoding (IDLE / RUN / DONE)
//   idx_w   : index counter width helper, never narrower than 1 bit
package cla_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_t;

  function automatic int idx_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk_add_seq_look_ahead16bit.sv
// look_ahead16bit: combinational 16-bit carry-lookahead adder.
// Two-level lookahead: four 4-bit groups produce group generate/propagate,
// and a second level derives the carry into each group directly from cin.
// Ports:
//   a, b  in  16  operands
//   cin   in  1   carry-in
//   s     out 16  sum
//   cout  out 1   carry-out
module look_ahead16bit
  import cla_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  cg;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    gg   = '0;
    pg   = '0;
    cg   = '0;
    c    = '0;
    cout = 1'b0;

    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end

    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    cout  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end

    s = p ^ c;
  end

endmodule

// File: rtl/cla_chunk_add_seq.sv
// cla_chunk_add_seq: multi-precision adder sequencer.
// Accepts WIDTH-bit operands over in_valid/in_ready, adds them CHUNK_W bits
// per cycle through a single look_ahead16bit (carry held in carry_r between
// chunks), then presents {cout,sum} over out_valid/out_ready.
// Optional macro CLA_SUBTRACT_EN adds the sub port (sum = a - b when set).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in   operands/cin valid       in_ready   out  can accept
//   a, b       in   WIDTH operands           cin        in   carry-in
//   sub        in   subtract select (CLA_SUBTRACT_EN only)
//   out_valid  out  result valid             out_ready  in   result taken
//   sum        out  WIDTH result             cout       out  top carry-out
module cla_chunk_add_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNKS = WIDTH / CHUNK_W;
  localparam int IDX_W  = idx_w(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  st_t              state;
  st_t              state_next;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic             accept;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;
  logic [CHUNK_W-1:0] chunk_s;
  logic               chunk_cout;

  assign accept  = in_valid && in_ready;
  assign chunk_a = a_r[idx*CHUNK_W +: CHUNK_W];
  assign chunk_b = b_r[idx*CHUNK_W +: CHUNK_W];

  look_ahead16bit u_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_r),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is masked by rst so nothing is accepted
  // on a reset edge.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, per-chunk sum write-back and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx <= '0;
            a_r <= a;
`ifdef CLA_SUBTRACT_EN
            // Two's-complement subtract: invert b and force carry-in to 1.
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
`else
            b_r     <= b;
            carry_r <= cin;
`endif
          end
        end
        RUN: begin
          sum[idx*CHUNK_W +: CHUNK_W] <= chunk_s;
          carry_r <= chunk_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) cout <= chunk_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_chunk_add_seq.sv
module tb_cla_chunk_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
`ifdef CLA_SUBTRACT_EN
  logic        sub = 1'b0;
  logic        n_sub = 1'b0;
`endif

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [15:0] n_a = '0;
  logic [15:0] n_b = '0;
  logic        n_cin = 1'b0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b0;
  logic [15:0] n_sum;
  logic        n_cout;

  cla_chunk_add_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  cla_chunk_add_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .a         (n_a),
    .b         (n_b),
    .cin       (n_cin),
`ifdef CLA_SUBTRACT_EN
    .sub       (n_sub),
`endif
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .sum       (n_sum),
    .cout      (n_cout)
  );

  // Drive one operation into the 64-bit DUT, return cycles from accepting
  // edge to out_valid (-1 on timeout).
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tcin, input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin;
`ifdef CLA_SUBTRACT_EN
    sub = tsub;
`else
    if (tsub) $display("note: subtract requested without subtract build");
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 64'd0) begin failures++; $display("FAIL reset_sum got=%h want=0", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (n_in_ready !== 1'b0) begin failures++; $display("FAIL reset_n_in_ready got=%b want=0", n_in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_ripple();
    int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ripple_latency got=%0d want=4", lat); end
    checks++; if (sum !== 64'd0) begin failures++; $display("FAIL ripple_sum got=%h want=0", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b want=1", cout); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_in_ready got=%b want=0", in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ripple_release got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ripple_idle got=%b want=1", in_ready); end
  endtask

  // out_ready is held high from before the op: it must not shorten RUN.
  task automatic test_pattern();
    int lat;
    out_ready = 1'b1;
    run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL pattern_latency got=%0d want=4", lat); end
    checks++; if (sum !== 64'h0011_0022_0033_0045) begin failures++; $display("FAIL pattern_sum got=%h want=0011002200330045", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL pattern_cout got=%b want=0", cout); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pattern_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_hold();
    int lat;
    run_op(64'h8000_0000_0000_1234, 64'h8000_0000_0000_1111, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL hold_latency got=%0d want=4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 64'd100 + 64'(i);
      b = 64'd200;
      @(posedge clk); #1;
      checks++; if (sum !== 64'h0000_0000_0000_2345) begin failures++; $display("FAIL hold_sum[%0d] got=%h want=2345", i, sum); end
      checks++; if (cout !== 1'b1) begin failures++; $display("FAIL hold_cout[%0d] got=%b want=1", i, cout); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] got=%b want=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid[%0d] got=%b want=1", i, out_valid); end
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b want=0", out_valid); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_not_queued got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0001_0000_0001_0000; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready_high got=%b want=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready_after got=%b want=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_out_valid got=%0d want=0", seen); end
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL midrst_latency got=%0d want=4", lat); end
    checks++; if (sum !== 64'd7) begin failures++; $display("FAIL midrst_sum got=%h want=7", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b want=0", cout); end
    release_result();
  endtask

`ifdef CLA_SUBTRACT_EN
  task automatic test_subtract();
    int lat;
    run_op(64'd5, 64'd7, 1'b0, 1'b1, lat);
    checks++; if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL sub_neg_sum got=%h want=fffffffffffffffe", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL sub_neg_cout got=%b want=0", cout); end
    release_result();
    run_op(64'd7, 64'd5, 1'b1, 1'b1, lat);
    checks++; if (sum !== 64'd2) begin failures++; $display("FAIL sub_pos_sum got=%h want=2", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL sub_pos_cout got=%b want=1", cout); end
    release_result();
    run_op(64'd7, 64'd5, 1'b1, 1'b0, lat);
    checks++; if (sum !== 64'd13) begin failures++; $display("FAIL sub_off_sum got=%h want=d", sum); end
    release_result();
    sub = 1'b0;
  endtask
`endif

  task automatic test_width16();
    int lat;
    @(negedge clk);
    checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL w16_in_ready got=%b want=1", n_in_ready); end
    n_a = 16'h8000; n_b = 16'h8000; n_cin = 1'b0;
    n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n_out_valid) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 1) begin failures++; $display("FAIL w16_latency got=%0d want=1", lat); end
    checks++; if (n_sum !== 16'h0000) begin failures++; $display("FAIL w16_sum got=%h want=0", n_sum); end
    checks++; if (n_cout !== 1'b1) begin failures++; $display("FAIL w16_cout got=%b want=1", n_cout); end
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0;
    checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL w16_release got=%b want=0", n_out_valid); end
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_pattern();
    test_hold();
    test_reset_mid();
`ifdef CLA_SUBTRACT_EN
    test_subtract();
`endif
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
